// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_unit_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push,
    input  fq_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output fq_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // A push into a full queue is accepted only when a pop frees a slot this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc register, combinational imem access, fetch queue to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag that stops fetch.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] target;
    logic              fetch_stall;
    logic              fetch;
    logic              deq;
    logic              q_full;
    logic              q_empty;
    fq_entry_t         q_head;
    fq_entry_t         enq_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= |redirect_pc[1:0];
        end
    end

    assign fetch_misalign = misalign_q;
    assign fetch_stall    = halt | misalign_q;
    assign target         = redirect_pc;
`else
    assign fetch_stall    = halt;
    assign target         = redirect_pc & ~32'd3;
`endif

    assign imem_addr = pc;
    assign deq       = !q_empty && id_ready;
    assign fetch     = !redirect_valid && !fetch_stall && (!q_full || deq);
    assign enq_entry = '{pc: pc, instr: imem_instr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= target;
        end else if (fetch) begin
            pc <= pc + PC_INC;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (fetch),
        .push_data(enq_entry),
        .pop      (deq),
        .full     (q_full),
        .empty    (q_empty),
        .head     (q_head)
    );

    // Head fields are forced to zero while the queue is empty so decode never sees stale data.
    assign id_valid    = !q_empty;
    assign id_instr    = q_empty ? '0 : q_head.instr;
    assign id_pc       = q_empty ? '0 : q_head.pc;
    assign id_pc_plus4 = q_empty ? '0 : q_head.pc + PC_INC;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic on two instances,
// checked against a queue-based reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ready     [2];
    logic        obs_valid [2];
    logic [31:0] obs_instr [2];
    logic [31:0] obs_pc    [2];
    logic [31:0] obs_p4    [2];
    logic [31:0] obs_addr  [2];
    logic [31:0] imem_word [2];
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        obs_mis   [2];
`endif

    logic [31:0] m_pc  [2];
    logic [63:0] m_q   [2][$];
    logic        m_mis [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F);
    endfunction

    assign imem_word[0] = mem_word(obs_addr[0]);
    assign imem_word[1] = mem_word(obs_addr[1]);

    fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (obs_addr[0]),
        .imem_instr    (imem_word[0]),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .id_ready      (ready[0]),
        .id_valid      (obs_valid[0]),
        .id_instr      (obs_instr[0]),
        .id_pc         (obs_pc[0]),
        .id_pc_plus4   (obs_p4[0])
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign(obs_mis[0])
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (obs_addr[1]),
        .imem_instr    (imem_word[1]),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .id_ready      (ready[1]),
        .id_valid      (obs_valid[1]),
        .id_instr      (obs_instr[1]),
        .id_pc         (obs_pc[1]),
        .id_pc_plus4   (obs_p4[1])
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign(obs_mis[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: a pc and a list of {pc, instr} entries bounded by the queue depth.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int n;
            bit take;
            n = m_q[i].size();
            take = (n > 0) && ready[i];
            if (!rst_n) begin
                m_pc[i] = (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
                m_q[i].delete();
                m_mis[i] = 1'b0;
            end else if (redirect_valid) begin
                m_q[i].delete();
`ifdef FETCH_MISALIGN_CHECK_EN
                m_pc[i]  = redirect_pc;
                m_mis[i] = (redirect_pc % 4) != 0;
`else
                m_pc[i]  = (redirect_pc / 4) * 4;
`endif
            end else begin
                if (take) void'(m_q[i].pop_front());
                if (!halt && !m_mis[i] && (n < ((i == 0) ? 2 : 4) || take)) begin
                    m_q[i].push_back({m_pc[i], mem_word(m_pc[i])});
                    m_pc[i] = m_pc[i] + 32'd4;
                end
            end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            string nm;
            bit v;
            logic [31:0] hp;
            logic [31:0] hi;
            nm = (i == 0) ? "A" : "B";
            v  = m_q[i].size() != 0;
            hp = v ? m_q[i][0][63:32] : 32'h0;
            hi = v ? m_q[i][0][31:0] : 32'h0;
            chk({nm, ".model.id_valid"}, 32'(obs_valid[i]), 32'(v));
            chk({nm, ".model.id_pc"}, obs_pc[i], hp);
            chk({nm, ".model.id_instr"}, obs_instr[i], hi);
            chk({nm, ".model.id_pc_plus4"}, obs_p4[i], v ? hp + 32'd4 : 32'h0);
            chk({nm, ".model.imem_addr"}, obs_addr[i], m_pc[i]);
`ifdef FETCH_MISALIGN_CHECK_EN
            chk({nm, ".model.fetch_misalign"}, 32'(obs_mis[i]), 32'(m_mis[i]));
`endif
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("rst.a_valid", 32'(obs_valid[0]), 32'd0);
        chk("rst.a_instr", obs_instr[0], 32'h0);
        chk("rst.a_pc", obs_pc[0], 32'h0);
        chk("rst.a_pc_plus4", obs_p4[0], 32'h0);
        chk("rst.a_addr", obs_addr[0], 32'h0);
        chk("rst.b_addr", obs_addr[1], 32'hFFFF_FFF8);

        rst_n = 1'b1;
        tick();
        chk("first.a_valid", 32'(obs_valid[0]), 32'd1);
        chk("first.a_instr", obs_instr[0], 32'h2008_0005);
        chk("first.a_pc", obs_pc[0], 32'h0);
        chk("first.a_pc_plus4", obs_p4[0], 32'h4);
        chk("wrap.b_pc0", obs_pc[1], 32'hFFFF_FFF8);

        ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.a_pc", obs_pc[0], 32'h0);
            chk("stall.a_addr", obs_addr[0], 32'h8);
            if (i == 0) chk("wrap.b_pc1", obs_pc[1], 32'hFFFF_FFFC);
            if (i == 1) begin
                chk("wrap.b_pc2", obs_pc[1], 32'h0);
                chk("wrap.b_pc_plus4", obs_p4[1], 32'h4);
            end
        end

        ready[0] = 1'b1;
        chk("drain.a_pc0", obs_pc[0], 32'h0);
        tick();
        chk("drain.a_pc4", obs_pc[0], 32'h4);
        tick();
        chk("drain.a_pc8", obs_pc[0], 32'h8);
        tick();
        chk("drain.a_pc12", obs_pc[0], 32'hC);

        // Fill the depth-2 queue, then redirect with a same-cycle dequeue.
        ready[0] = 1'b0;
        tick();
        chk("full.a_addr", obs_addr[0], 32'h14);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        ready[0] = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("redir.a_valid_n1", 32'(obs_valid[0]), 32'd0);
        chk("redir.a_addr_n1", obs_addr[0], 32'h100);
        tick();
        chk("redir.a_valid_n2", 32'(obs_valid[0]), 32'd1);
        chk("redir.a_pc_n2", obs_pc[0], 32'h100);

        ready[0] = 1'b0;
        tick();
        chk("halt.a_addr_pre", obs_addr[0], 32'h108);
        halt = 1'b1;
        ready[0] = 1'b1;
        tick();
        chk("halt.a_pc_drain", obs_pc[0], 32'h104);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt.a_valid", 32'(obs_valid[0]), 32'd0);
            chk("halt.a_addr", obs_addr[0], 32'h108);
        end
        halt = 1'b0;
        tick();
        chk("resume.a_pc", obs_pc[0], 32'h108);

        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis.a_flag", 32'(obs_mis[0]), 32'd1);
        chk("mis.a_valid", 32'(obs_valid[0]), 32'd0);
        tick();
        chk("mis.a_no_enq", 32'(obs_valid[0]), 32'd0);
        chk("mis.a_flag_held", 32'(obs_mis[0]), 32'd1);
`else
        chk("align.a_addr", obs_addr[0], 32'h100);
        tick();
        chk("align.a_pc", obs_pc[0], 32'h100);
`endif
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("re200.a_addr", obs_addr[0], 32'h200);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("re200.a_flag", 32'(obs_mis[0]), 32'd0);
`endif
        tick();
        chk("re200.a_valid", 32'(obs_valid[0]), 32'd1);
        chk("re200.a_pc", obs_pc[0], 32'h200);

        for (int c = 0; c < 400; c++) begin
            logic [31:0] r;
            r = $urandom;
            rst_n = $urandom_range(0, 99) != 0;
            halt = $urandom_range(0, 9) == 0;
            redirect_valid = $urandom_range(0, 11) == 0;
            redirect_pc = ($urandom_range(0, 3) == 0) ? r : (r & ~32'd3);
            ready[0] = $urandom_range(0, 2) != 0;
            ready[1] = $urandom_range(0, 2) != 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
